// File: rtl/coco_sketch_ctrl.sv
// Sequencer/arbiter sharing the counter and ID RAM ports between insertion, host clear and host query.
// Clears both RAMs after reset; drains the insert pipeline before any host access.
module coco_sketch_ctrl #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              e_in_valid,
    output logic              e_in_ready,
    output logic              e_out_valid,
    input  logic              pipe_busy,
    input  logic              clr_req,
    output logic              clr_busy,
    input  logic              q_valid,
    input  logic [ADDR_W-1:0] q_addr,
    output logic              q_ready,
    output logic              r_valid,
    output logic [DATA_W-1:0] r_count,
    output logic [DATA_W-1:0] r_id,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_raddr,
    input  logic [DATA_W-1:0] cnt_dout,
    input  logic [DATA_W-1:0] id_dout,
    output logic              dp_sel
);

    localparam int WC_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_QRD,
        S_QWAIT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic              pend_clr;
    logic [WC_W-1:0]   wcnt;
    logic [ADDR_W-1:0] qaddr_q;

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state    <= S_CLEAR;
            clr_cnt  <= '0;
            pend_clr <= 1'b0;
            wcnt     <= '0;
            qaddr_q  <= '0;
            r_valid  <= 1'b0;
            r_count  <= '0;
            r_id     <= '0;
        end else begin
            state   <= state_nxt;
            r_valid <= 1'b0;
            case (state)
                // counter wraps back to 0 on the last write, ready for the next clear
                S_CLEAR: clr_cnt <= clr_cnt + ADDR_W'(1);
                S_RUN: begin
                    if (clr_req || q_valid) pend_clr <= clr_req;
                end
                S_QRD: begin
                    qaddr_q <= q_addr;
                    wcnt    <= WC_W'(RD_LAT);
                end
                S_QWAIT: begin
                    wcnt <= wcnt - WC_W'(1);
                    if (wcnt == WC_W'(1)) begin
                        r_valid <= 1'b1;
                        r_count <= cnt_dout;
                        r_id    <= id_dout;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nxt  = state;
        e_in_ready = 1'b0;
        q_ready    = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = '0;
        mem_rd_en  = 1'b0;
        mem_raddr  = qaddr_q;
        dp_sel     = 1'b0;
        clr_busy   = 1'b0;
        case (state)
            S_CLEAR: begin
                mem_we    = 1'b1;
                mem_waddr = clr_cnt;
                clr_busy  = 1'b1;
                if (clr_cnt == {ADDR_W{1'b1}}) state_nxt = S_RUN;
            end
            S_RUN: begin
                dp_sel     = 1'b1;
                e_in_ready = !(clr_req || q_valid);
                if (clr_req || q_valid) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                dp_sel = 1'b1;
                if (!pipe_busy) state_nxt = pend_clr ? S_CLEAR : S_QRD;
            end
            S_QRD: begin
                q_ready   = 1'b1;
                mem_rd_en = 1'b1;
                mem_raddr = q_addr;
                state_nxt = S_QWAIT;
            end
            S_QWAIT: begin
                if (wcnt == WC_W'(1)) state_nxt = S_RUN;
            end
            default: state_nxt = S_CLEAR;
        endcase
        // outputs show their idle values while reset is held
        if (rst) begin
            e_in_ready = 1'b0;
            q_ready    = 1'b0;
            mem_we     = 1'b0;
            mem_waddr  = '0;
            mem_rd_en  = 1'b0;
            mem_raddr  = '0;
            dp_sel     = 1'b0;
            clr_busy   = 1'b1;
        end
    end

    assign e_out_valid = e_in_valid & e_in_ready;
    assign mem_wdata   = '0;

endmodule

// File: tb/tb_coco_sketch_ctrl.sv
// Randomized bench for coco_sketch_ctrl with a latency-2 RAM model and an independent golden bucket array.
module tb_coco_sketch_ctrl;

    logic        sys_clk = 1'b0;
    logic        rst = 1'b1;
    logic        e_in_valid = 1'b0;
    logic        e_in_ready, e_out_valid;
    logic        pipe_busy = 1'b0;
    logic        clr_req = 1'b0;
    logic        clr_busy;
    logic        q_valid = 1'b0;
    logic [3:0]  q_addr = '0;
    logic        q_ready, r_valid;
    logic [31:0] r_count, r_id;
    logic        mem_we;
    logic [3:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_rd_en;
    logic [3:0]  mem_raddr;
    logic [31:0] cnt_dout, id_dout;
    logic        dp_sel;

    int total = 0;
    int bad = 0;

    logic [31:0] ram_c[16], ram_i[16];
    logic [31:0] rp_c, rp_i;
    logic        pre_we = 1'b0;
    logic [3:0]  pre_addr = '0;
    logic [31:0] pre_c = '0, pre_i = '0;
    logic [31:0] gold_c[16], gold_i[16];

    coco_sketch_ctrl #(.ADDR_W(4), .DATA_W(32), .RD_LAT(2)) dut (
        .sys_clk(sys_clk), .rst(rst),
        .e_in_valid(e_in_valid), .e_in_ready(e_in_ready), .e_out_valid(e_out_valid),
        .pipe_busy(pipe_busy), .clr_req(clr_req), .clr_busy(clr_busy),
        .q_valid(q_valid), .q_addr(q_addr), .q_ready(q_ready),
        .r_valid(r_valid), .r_count(r_count), .r_id(r_id),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .mem_rd_en(mem_rd_en), .mem_raddr(mem_raddr),
        .cnt_dout(cnt_dout), .id_dout(id_dout), .dp_sel(dp_sel)
    );

    always #5 sys_clk = ~sys_clk;

    // RAM model: address in cycle T, data visible in cycle T+2
    always @(posedge sys_clk) begin
        if (pre_we) begin
            ram_c[pre_addr] <= pre_c;
            ram_i[pre_addr] <= pre_i;
        end
        if (mem_we) begin
            ram_c[mem_waddr] <= mem_wdata;
            ram_i[mem_waddr] <= mem_wdata;
        end
        if (mem_rd_en) begin
            rp_c <= ram_c[mem_raddr];
            rp_i <= ram_i[mem_raddr];
        end
        cnt_dout <= rp_c;
        id_dout  <= rp_i;
    end

    task automatic cyc;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic smp;
        @(negedge sys_clk);
    endtask

    task automatic preload(input logic [3:0] a, input logic [31:0] c, input logic [31:0] i);
        pre_we = 1'b1; pre_addr = a; pre_c = c; pre_i = i;
        gold_c[a] = c; gold_i[a] = i;
        cyc;
        pre_we = 1'b0;
    endtask

    // expects the current cycle to be the first clear write
    task automatic chk_clear(input string tag);
        for (int i = 0; i < 16; i++) begin
            e_in_valid = 1'($urandom_range(0, 1));
            smp;
            total++;
            if (mem_we !== 1'b1 || mem_waddr !== 4'(i) || clr_busy !== 1'b1 || dp_sel !== 1'b0 ||
                e_in_ready !== 1'b0 || e_out_valid !== 1'b0 || q_ready !== 1'b0) begin
                bad++;
                $display("FAIL %s clear cycle %0d: we=%b waddr=%0d busy=%b dp=%b rdy=%b out=%b qr=%b, need we=1 waddr=%0d busy=1 dp=0 rdy=0 out=0 qr=0",
                         tag, i, mem_we, mem_waddr, clr_busy, dp_sel, e_in_ready, e_out_valid, q_ready, i);
            end
            cyc;
        end
        e_in_valid = 1'b0;
        for (int a = 0; a < 16; a++) begin
            gold_c[a] = '0;
            gold_i[a] = '0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cyc;
        smp;
        total++;
        if (mem_we !== 1'b0 || clr_busy !== 1'b1 || e_in_ready !== 1'b0 || q_ready !== 1'b0 ||
            dp_sel !== 1'b0 || mem_rd_en !== 1'b0 || r_valid !== 1'b0 || r_count !== 32'd0 || r_id !== 32'd0) begin
            bad++;
            $display("FAIL reset outputs: we=%b busy=%b rdy=%b qr=%b dp=%b rd=%b rv=%b rc=%h ri=%h, need 0 1 0 0 0 0 0 0 0",
                     mem_we, clr_busy, e_in_ready, q_ready, dp_sel, mem_rd_en, r_valid, r_count, r_id);
        end
        cyc;
        rst = 1'b0;
    endtask

    task automatic test_clear_after_reset;
        chk_clear("post_reset");
        smp;
        total++;
        if (clr_busy !== 1'b0 || e_in_ready !== 1'b1 || mem_we !== 1'b0 || dp_sel !== 1'b1) begin
            bad++;
            $display("FAIL clear_end: busy=%b rdy=%b we=%b dp=%b, need 0 1 0 1", clr_busy, e_in_ready, mem_we, dp_sel);
        end
        cyc;
    endtask

    task automatic test_insert;
        int sent = 0;
        int seen = 0;
        for (int k = 0; k < 25; k++) begin
            logic v;
            v = (k < 5) ? 1'b1 : 1'($urandom_range(0, 1));
            e_in_valid = v;
            sent += int'(v);
            smp;
            seen += int'(e_out_valid);
            total++;
            if (e_out_valid !== v || e_in_ready !== 1'b1 || mem_we !== 1'b0 || dp_sel !== 1'b1) begin
                bad++;
                $display("FAIL insert cycle %0d: out=%b rdy=%b we=%b dp=%b, need out=%b rdy=1 we=0 dp=1",
                         k, e_out_valid, e_in_ready, mem_we, dp_sel, v);
            end
            cyc;
        end
        e_in_valid = 1'b0;
        total++;
        if (seen !== sent) begin
            bad++;
            $display("FAIL insert_count: forwarded=%0d need %0d", seen, sent);
        end
    endtask

    // current cycle must be RUN; busy>=1 cycles of pipe_busy; clr_at<0 means no clear request
    task automatic do_query(input logic [3:0] a, input int busy, input int clr_at, input string tag);
        int qk, rk;
        logic exp_qr, exp_rv, exp_dp, exp_rdy;
        qk = busy + 1;
        rk = qk + 3;
        q_valid = 1'b1;
        q_addr = a;
        e_in_valid = 1'b1;
        for (int k = 0; k <= rk; k++) begin
            pipe_busy = (k < busy);
            if (k == clr_at) clr_req = 1'b1;
            smp;
            exp_qr  = (k == qk);
            exp_rv  = (k == rk);
            exp_dp  = (k < qk) || (k == rk);
            exp_rdy = (k == rk) && (clr_at < 0);
            total++;
            if (q_ready !== exp_qr || mem_rd_en !== exp_qr) begin
                bad++;
                $display("FAIL %s q_ready k=%0d: qr=%b rd=%b need %b", tag, k, q_ready, mem_rd_en, exp_qr);
            end
            total++;
            if (r_valid !== exp_rv || dp_sel !== exp_dp || mem_we !== 1'b0) begin
                bad++;
                $display("FAIL %s seq k=%0d: rv=%b dp=%b we=%b need rv=%b dp=%b we=0", tag, k, r_valid, dp_sel, mem_we, exp_rv, exp_dp);
            end
            total++;
            if (e_in_ready !== exp_rdy || e_out_valid !== exp_rdy) begin
                bad++;
                $display("FAIL %s ready k=%0d: rdy=%b out=%b need %b", tag, k, e_in_ready, e_out_valid, exp_rdy);
            end
            if (k == qk) begin
                total++;
                if (mem_raddr !== a) begin
                    bad++;
                    $display("FAIL %s raddr: got %0d need %0d", tag, mem_raddr, a);
                end
            end
            if (k == rk) begin
                total++;
                if (r_count !== gold_c[a] || r_id !== gold_i[a]) begin
                    bad++;
                    $display("FAIL %s result addr %0d: count=%h id=%h need count=%h id=%h", tag, a, r_count, r_id, gold_c[a], gold_i[a]);
                end
            end
            cyc;
            if (k == qk) q_valid = 1'b0;
        end
        e_in_valid = 1'b0;
        pipe_busy = 1'b0;
        if (clr_at >= 0) begin
            clr_req = 1'b0;
            smp;
            total++;
            if (mem_we !== 1'b0 || dp_sel !== 1'b1 || e_in_ready !== 1'b0 || r_valid !== 1'b0) begin
                bad++;
                $display("FAIL %s drain: we=%b dp=%b rdy=%b rv=%b need 0 1 0 0", tag, mem_we, dp_sel, e_in_ready, r_valid);
            end
            cyc;
            chk_clear({tag, "_clr"});
        end
    endtask

    task automatic test_query_basic;
        preload(4'd7, 32'h2A, 32'hDEADBEEF);
        do_query(4'd7, 3, -1, "query7");
    endtask

    task automatic test_clr_and_query;
        preload(4'd3, 32'h1 + $urandom_range(0, 1000), $urandom);
        clr_req = 1'b1;
        q_valid = 1'b1;
        q_addr = 4'd3;
        smp;
        total++;
        if (e_in_ready !== 1'b0) begin
            bad++;
            $display("FAIL both_req ready: rdy=%b need 0", e_in_ready);
        end
        cyc;
        clr_req = 1'b0;
        smp;
        total++;
        if (mem_we !== 1'b0 || q_ready !== 1'b0 || dp_sel !== 1'b1) begin
            bad++;
            $display("FAIL both_req drain: we=%b qr=%b dp=%b need 0 0 1", mem_we, q_ready, dp_sel);
        end
        cyc;
        chk_clear("both_req");
        do_query(4'd3, 1, -1, "both_query");
    endtask

    task automatic test_reset_midclear;
        preload(4'd12, 32'h55, 32'h66);
        clr_req = 1'b1;
        cyc;
        clr_req = 1'b0;
        cyc;
        for (int i = 0; i < 9; i++) begin
            smp;
            total++;
            if (mem_we !== 1'b1 || mem_waddr !== 4'(i)) begin
                bad++;
                $display("FAIL midclear pre cycle %0d: we=%b waddr=%0d need 1 %0d", i, mem_we, mem_waddr, i);
            end
            cyc;
        end
        rst = 1'b1;
        smp;
        total++;
        if (mem_we !== 1'b0 || clr_busy !== 1'b1) begin
            bad++;
            $display("FAIL midclear reset: we=%b busy=%b need 0 1", mem_we, clr_busy);
        end
        cyc;
        rst = 1'b0;
        chk_clear("midclear");
        do_query(4'd12, 1, -1, "midclear_q");
    endtask

    task automatic test_clr_in_qwait;
        preload(4'd5, $urandom, $urandom);
        do_query(4'd5, 2, 4, "qwait_clr");
        do_query(4'd5, 1, -1, "after_qwait_clr");
    endtask

    task automatic test_back_to_back;
        for (int n = 0; n < 5; n++) begin
            logic [3:0] a;
            a = 4'($urandom_range(0, 15));
            preload(a, $urandom, $urandom);
            do_query(a, int'($urandom_range(1, 4)), -1, "b2b");
        end
    endtask

    initial begin
        test_reset;
        test_clear_after_reset;
        test_insert;
        test_query_basic;
        test_clr_and_query;
        test_reset_midclear;
        test_clr_in_qwait;
        test_back_to_back;
        test_insert;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/coco_sketch_ctrl.md
Name: coco_sketch_ctrl

Overview:
Sequencer and port arbiter for the sketch counter RAM and ID RAM. It shares the RAM write/read ports between three users: the insertion datapath, a host clear command, and a host single-bucket query. It clears both RAMs automatically after reset. Before a clear or query it pauses insertion and waits for the insert pipeline to drain, so host accesses never interleave with in-flight counter and ID updates.

Parameters:
ADDR_W, 16, bucket address width; the RAM holds 2**ADDR_W entries.
DATA_W, 32, counter and ID width.
RD_LAT, 2, RAM read latency in cycles, from address presented to dout valid.

Ports:
sys_clk  in  1  system clock
rst  in  1  synchronous reset, active-high
e_in_valid  in  1  upstream element valid
e_in_ready  out  1  controller accepts insertion
e_out_valid  out  1  element forwarded to insert datapath (= e_in_valid & e_in_ready)
pipe_busy  in  1  insert datapath has elements in flight
clr_req  in  1  host clear request, level, sampled in RUN
clr_busy  out  1  clear in progress
q_valid  in  1  host query request
q_addr  in  ADDR_W  bucket to query
q_ready  out  1  query accepted this cycle
r_valid  out  1  query result valid, 1-cycle pulse
r_count  out  DATA_W  counter value of queried bucket
r_id  out  DATA_W  ID value of queried bucket
mem_we  out  1  host-side write enable, to both RAMs
mem_waddr  out  ADDR_W  write address
mem_wdata  out  DATA_W  write data (always 0)
mem_rd_en  out  1  host-side read enable
mem_raddr  out  ADDR_W  read address
cnt_dout  in  DATA_W  counter RAM read data
id_dout  in  DATA_W  ID RAM read data
dp_sel  out  1  1 = datapath owns RAM port, 0 = controller owns it

Behaviour:
Reset (rst=1 at a posedge):
- State goes to CLEAR, and the clear address counter goes to 0.
- e_in_ready=0, q_ready=0, r_valid=0, r_count=0, r_id=0, mem_we=0, mem_waddr=0, mem_wdata=0, mem_rd_en=0, mem_raddr=0, dp_sel=0, clr_busy=1.
- Reset mid-clear or mid-query aborts the operation and restarts the clear from address 0. A pending query is dropped.

States:
- CLEAR:
  - mem_we=1, mem_waddr=clr_cnt, mem_wdata=0; clr_cnt increments every cycle.
  - After writing address 2**ADDR_W-1, go to RUN. The counter wraps to 0.
  - A clear takes exactly 2**ADDR_W cycles. clr_busy=1 throughout.
- RUN:
  - dp_sel=1, e_in_ready=1, mem_we=0, mem_rd_en=0.
  - Priority is clr_req over q_valid over insertion.
  - If clr_req or q_valid is high, e_in_ready drops that same cycle (combinational) and the next state is DRAIN. The pending operation type is latched; clear wins if both are high.
- DRAIN:
  - e_in_ready=0, dp_sel=1.
  - Stay while pipe_busy=1. When pipe_busy=0, go to CLEAR (if a clear was latched) or QRD.
- QRD:
  - dp_sel=0, q_ready=1 for one cycle, mem_rd_en=1, mem_raddr=q_addr; q_addr is latched.
  - A wait counter loads RD_LAT; go to QWAIT.
- QWAIT:
  - The counter decrements each cycle.
  - When it reaches 1, capture cnt_dout and id_dout into r_count and r_id, pulse r_valid the next cycle, and return to RUN.
  - The result appears RD_LAT+1 cycles after the q_ready cycle.
  - r_count and r_id hold until the next query result.

Handshake and boundary rules:
- Query handshake: the host holds q_valid and q_addr until q_ready=1. q_ready is never asserted outside QRD.
- clr_req or q_valid arriving during CLEAR, DRAIN, QRD or QWAIT is not acted on until the block returns to RUN.
- clr_req and q_valid asserted together: the clear runs first, then the query is serviced from RUN. The host keeps q_valid high.
- No element is lost: e_out_valid is never asserted when e_in_ready=0.
- ADDR_W arithmetic is modulo 2**ADDR_W; no overflow flag is needed.

Test Plan:
1. Bench with ADDR_W=4, RD_LAT=2, and rst high for 2 cycles → mem_we=1 for exactly 16 cycles with mem_waddr 0..15; clr_busy falls after address 15; e_in_ready=1 on the next cycle.
2. In RUN, e_in_valid=1 for 5 cycles → e_out_valid=1 for 5 cycles; mem_we=0 throughout.
3. In RUN, q_valid=1 with q_addr=7, pipe_busy=1 for 3 cycles; model RAM bucket 7 holds count=0x2A and id=0xDEADBEEF:
   - e_in_ready drops immediately; q_ready rises 1 cycle after pipe_busy falls.
   - r_valid pulses 3 cycles after q_ready, with r_count=0x2A and r_id=0xDEADBEEF.
4. clr_req and q_valid (q_addr=3) asserted in the same RUN cycle → a full 16-cycle clear, then the query → r_count=0, r_id=0.
5. rst pulsed at clear address 9 → clear restarts at address 0 and completes 16 writes.
6. clr_req asserted while in QWAIT → the query result is delivered first, then DRAIN, then a 16-cycle clear.
